// File: rtl/ucie_ctl_rx_buffer.sv
// ucie_ctl_rx_buffer
//   RX-side word buffer of the UCIe controller. Captures words from the RX
//   datapath while the RX FSM enables it and presents them first-word-fall-
//   through to the protocol-layer consumer over a valid/ready handshake.
//   A write into a full buffer (with no simultaneous pop) is dropped and
//   reported by a one-cycle o_overflow_detected pulse on the following cycle.
//
// Ports
//   i_clk               clock, rising edge
//   i_rst               asynchronous, active-low reset
//   i_buffer_enable     1 = buffer active, 0 = held flushed (synchronous clear)
//   i_wr_valid/i_wr_data  RX datapath word
//   o_rd_valid/o_rd_data  head word to consumer (FWFT)
//   i_rd_ready          consumer accepts head word
//   o_full/o_empty      occupancy == DEPTH / occupancy == 0
//   o_count             occupancy, 0..DEPTH
//   o_overflow_detected one-cycle pulse per dropped word
//   o_overflow_count    (UCIE_CTL_RX_BUF_OVF_CNT_EN only) saturating 8-bit
//                       count of dropped words
//
// Optional feature macro: UCIE_CTL_RX_BUF_OVF_CNT_EN

module ucie_ctl_rx_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_buffer_enable,
  input  logic                  i_wr_valid,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_rd_valid,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  input  logic                  i_rd_ready,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_count,
`ifdef UCIE_CTL_RX_BUF_OVF_CNT_EN
  output logic [7:0]            o_overflow_count,
`endif
  output logic                  o_overflow_detected
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH_LOG2:0]   r_wr_ptr;
  logic [DEPTH_LOG2:0]   r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_overflow;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push_req;
  logic w_push;
  logic w_drop;

  // MSB of each pointer is the wrap bit; same address with differing wrap
  // bits means the writer is a full lap ahead of the reader.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]) &&
                   (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]);

  assign o_rd_valid = i_buffer_enable & ~w_empty;
  assign o_rd_data  = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];

  assign w_pop      = o_rd_valid & i_rd_ready;
  assign w_push_req = i_buffer_enable & i_wr_valid;
  // A pop in the same cycle frees the slot, so a full buffer still accepts.
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_drop     = w_push_req & w_full & ~w_pop;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (!i_buffer_enable) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
      r_overflow <= w_drop;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= i_wr_data;
    end
  end

  assign o_full              = w_full;
  assign o_empty             = w_empty;
  assign o_count             = r_count;
  assign o_overflow_detected = r_overflow;

`ifdef UCIE_CTL_RX_BUF_OVF_CNT_EN
  logic [7:0] r_ovf_cnt;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_ovf_cnt <= '0;
    end else if (!i_buffer_enable) begin
      r_ovf_cnt <= '0;
    end else if (w_drop && (r_ovf_cnt != 8'hFF)) begin
      r_ovf_cnt <= r_ovf_cnt + 8'd1;
    end
  end

  assign o_overflow_count = r_ovf_cnt;
`endif

endmodule

// File: tb/tb_ucie_ctl_rx_buffer.sv
module tb_ucie_ctl_rx_buffer;

  localparam int DW    = 32;
  localparam int DL2   = 3;
  localparam int DEPTH = 8;

  logic          i_clk;
  logic          i_rst;
  logic          i_buffer_enable;
  logic          i_wr_valid;
  logic [DW-1:0] i_wr_data;
  logic          o_rd_valid;
  logic [DW-1:0] o_rd_data;
  logic          i_rd_ready;
  logic          o_full;
  logic          o_empty;
  logic [DL2:0]  o_count;
  logic          o_overflow_detected;
`ifdef UCIE_CTL_RX_BUF_OVF_CNT_EN
  logic [7:0]    o_overflow_count;
`endif

  ucie_ctl_rx_buffer #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL2)) dut (
    .i_clk               (i_clk),
    .i_rst               (i_rst),
    .i_buffer_enable     (i_buffer_enable),
    .i_wr_valid          (i_wr_valid),
    .i_wr_data           (i_wr_data),
    .o_rd_valid          (o_rd_valid),
    .o_rd_data           (o_rd_data),
    .i_rd_ready          (i_rd_ready),
    .o_full              (o_full),
    .o_empty             (o_empty),
    .o_count             (o_count),
`ifdef UCIE_CTL_RX_BUF_OVF_CNT_EN
    .o_overflow_count    (o_overflow_count),
`endif
    .o_overflow_detected (o_overflow_detected)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;

  // Reference model: the buffer contents as a plain queue of words.
  logic [DW-1:0] q[$];
  logic          ovf_m;
  int            ocnt_m;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic exp_valid;
    exp_valid = i_buffer_enable && (q.size() > 0);
    chk("count", DW'(o_count), DW'(q.size()));
    chk("empty", DW'(o_empty), DW'(q.size() == 0));
    chk("full",  DW'(o_full),  DW'(q.size() == DEPTH));
    chk("rd_valid", DW'(o_rd_valid), DW'(exp_valid));
    chk("ovf", DW'(o_overflow_detected), DW'(ovf_m));
    if (exp_valid) chk("rd_data", o_rd_data, q[0]);
`ifdef UCIE_CTL_RX_BUF_OVF_CNT_EN
    chk("ovf_cnt", DW'(o_overflow_count), DW'(ocnt_m));
`endif
  endtask

  // One clock cycle: drive, check at negedge, then advance the model with
  // the buffer rules (pop first frees a slot for the same-cycle write).
  task automatic cycle(input logic en, input logic wv, input logic [DW-1:0] wd, input logic rr);
    logic pop;
    logic was_full;
    i_buffer_enable = en;
    i_wr_valid      = wv;
    i_wr_data       = wd;
    i_rd_ready      = rr;
    @(negedge i_clk);
    check_all();
    pop      = en && (q.size() > 0) && rr;
    was_full = (q.size() == DEPTH);
    @(posedge i_clk);
    #1;
    if (!en) begin
      q.delete();
      ovf_m  = 1'b0;
      ocnt_m = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (wv && (!was_full || pop)) q.push_back(wd);
      ovf_m = wv && was_full && !pop;
      if (ovf_m && ocnt_m < 255) ocnt_m++;
    end
  endtask

  initial begin
    i_rst = 1'b0;
    i_buffer_enable = 1'b0;
    i_wr_valid = 1'b0;
    i_wr_data = '0;
    i_rd_ready = 1'b0;
    q.delete();
    ovf_m = 1'b0;
    ocnt_m = 0;

    // Reset values
    @(negedge i_clk);
    chk("rst_count", DW'(o_count), 0);
    chk("rst_empty", DW'(o_empty), 1);
    chk("rst_full", DW'(o_full), 0);
    chk("rst_valid", DW'(o_rd_valid), 0);
    chk("rst_ovf", DW'(o_overflow_detected), 0);
    #2 i_rst = 1'b1;
    @(posedge i_clk); #1;

    // Write A0..A2 without reading, then drain in order
    for (int i = 0; i < 3; i++) cycle(1, 1, 32'hA0 + i, 0);
    chk("abc_count3", DW'(o_count), 3);
    chk("abc_empty0", DW'(o_empty), 0);
    for (int i = 0; i < 3; i++) begin
      chk("abc_order", o_rd_data, 32'hA0 + i);
      cycle(1, 0, 0, 1);
    end
    cycle(1, 0, 0, 1);

    // Fill to 8 then drop 0xDEAD
    for (int i = 0; i < DEPTH; i++) cycle(1, 1, 32'hB0 + i, 0);
    chk("fill_full", DW'(o_full), 1);
    cycle(1, 1, 32'hDEAD, 0);
    chk("drop_pulse", DW'(o_overflow_detected), 1);
    chk("drop_count8", DW'(o_count), 8);
    cycle(1, 0, 0, 0);
    chk("drop_pulse_end", DW'(o_overflow_detected), 0);

    // Full with simultaneous write 0xBEEF and pop
    cycle(1, 1, 32'hBEEF, 1);
    chk("wp_no_ovf", DW'(o_overflow_detected), 0);
    chk("wp_count8", DW'(o_count), 8);
    for (int i = 0; i < 7; i++) cycle(1, 0, 0, 1);
    chk("beef_8th", o_rd_data, 32'hBEEF);
    cycle(1, 0, 0, 1);
    cycle(1, 0, 0, 0);

    // Streaming 20 words with continuous pop: pointers wrap
    for (int i = 0; i < 20; i++) begin
      cycle(1, 1, 32'hC00 + i, 1);
      chk("stream_cnt_le1", DW'(o_count <= 1), 1);
    end
    cycle(1, 0, 0, 1);
    cycle(1, 0, 0, 0);

    // Hold 5 then flush via enable low with a write present
    for (int i = 0; i < 5; i++) cycle(1, 1, 32'hD0 + i, 0);
    cycle(0, 1, 32'hEEEE, 0);
    chk("flush_count", DW'(o_count), 0);
    chk("flush_ovf", DW'(o_overflow_detected), 0);
    cycle(1, 1, 32'hD9, 0);
    chk("flush_first", o_rd_data, 32'hD9);
    cycle(1, 0, 0, 1);
    cycle(1, 0, 0, 0);

    // Async reset mid-stream with 4 words held
    for (int i = 0; i < 4; i++) cycle(1, 1, 32'hF0 + i, 0);
    i_wr_valid = 1'b0;
    #2 i_rst = 1'b0;
    #1;
    chk("arst_count", DW'(o_count), 0);
    chk("arst_empty", DW'(o_empty), 1);
    chk("arst_valid", DW'(o_rd_valid), 0);
    chk("arst_full", DW'(o_full), 0);
    q.delete();
    ovf_m = 1'b0;
    ocnt_m = 0;
    @(negedge i_clk);
    #2 i_rst = 1'b1;
    @(posedge i_clk); #1;
    cycle(1, 0, 0, 1);
    cycle(1, 0, 0, 1);

`ifdef UCIE_CTL_RX_BUF_OVF_CNT_EN
    // Saturation of the drop counter
    for (int i = 0; i < DEPTH; i++) cycle(1, 1, i, 0);
    for (int i = 0; i < 260; i++) cycle(1, 1, 32'h5A5A, 0);
    cycle(1, 0, 0, 0);
    chk("ovf_cnt_sat", DW'(o_overflow_count), 255);
    cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
`endif

    // Randomized traffic against the queue model
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom % 16) != 0, $urandom_range(0, 3) != 0, $urandom,
            $urandom_range(0, 2) == 0);
    end
    cycle(1, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
